// File: rtl/task_pkg.sv
// Shared definitions for the task datapath result serializer.
package task_pkg;

  // Width of one element on the task manager byte stream
  localparam int BYTE_W = 8;

  // Serializer control states
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/word_serializer_fifo_if.sv
// Word input and byte output handshake bundle of the result serializer.
interface word_serializer_fifo_if #(
  parameter int WORD_BYTES = 4,
  parameter int SIZE_W     = 12
);
  import task_pkg::*;

  logic                           i_enb;
  logic [BYTE_W*WORD_BYTES-1:0]   i_data;
  logic                           i_last;
  logic                           o_ready;
  logic                           o_overflow;
  logic                           i_tmanager_ready;
  logic                           o_tanswer_ready;
  logic [BYTE_W-1:0]              o_tanswer_data;
  logic                           o_tanswer_data_last;
  logic [SIZE_W-1:0]              o_packet_size_in_bytes;
  logic                           o_busy;

  modport slave (
    input  i_enb, i_data, i_last, i_tmanager_ready,
    output o_ready, o_overflow, o_tanswer_ready, o_tanswer_data,
           o_tanswer_data_last, o_packet_size_in_bytes, o_busy
  );

  modport master (
    output i_enb, i_data, i_last, i_tmanager_ready,
    input  o_ready, o_overflow, o_tanswer_ready, o_tanswer_data,
           o_tanswer_data_last, o_packet_size_in_bytes, o_busy
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Registered first-word-fall-through FIFO; the head entry is always visible on rdData_o.
// A word written in one cycle becomes visible (non-empty) only from the next cycle on.
module sync_fifo_fwft #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wrEn_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic             rdEn_i,
  output logic [WIDTH-1:0] rdData_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doWrite, doRead;

  assign doWrite  = wrEn_i && !full_o;
  assign doRead   = rdEn_i && !empty_o;
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign rdData_o = mem_q[rdPtr_q];

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk_i) begin
    if (doWrite) mem_q[wrPtr_q] <= wrData_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWrite) wrPtr_q <= wrPtr_q + 1'b1;
      if (doRead)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doWrite, doRead})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/word_serializer_fifo.sv
// Buffers compute-core result words and streams them out byte by byte with
// packet-last marking, a saturating packet byte count and sticky overflow.
module word_serializer_fifo
  import task_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int SIZE_W     = 12
) (
  input logic                   i_clk,
  input logic                   i_rst,
  word_serializer_fifo_if.slave bus
);

  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  // FIFO entry: packet-last flag travels alongside its word
  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] word;
  } entry_t;

  entry_t            wrEntry, rdEntry;
  entry_t            shift_q, shift_d;
  ser_state_e        state_q, state_d;
  logic [IDX_W-1:0]  byteIdx_q, byteIdx_d, byteSel;
  logic [SIZE_W-1:0] runCnt_q, runCnt_d, pktSize_q, pktSize_d, runInc;
  logic [CNT_W-1:0]  fifoCount;
  logic [BYTE_W-1:0] outByte;
  logic              fifoFull, fifoEmpty, pop, xfer, lastByte, overflow_q;
  logic              tValid, tLast, busy;

  assign wrEntry  = '{last: bus.i_last, word: bus.i_data};
  assign xfer     = (state_q == SEND) && bus.i_tmanager_ready;
  assign lastByte = (byteIdx_q == LAST_IDX);
  assign runInc   = (runCnt_q == {SIZE_W{1'b1}}) ? runCnt_q : runCnt_q + 1'b1;

  sync_fifo_fwft #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .wrEn_i  (bus.i_enb),
    .wrData_i(wrEntry),
    .rdEn_i  (pop),
    .rdData_o(rdEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: load a word when idle, walk its bytes, chain the next word without a bubble
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    byteIdx_d = byteIdx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop       = 1'b1;
          shift_d   = rdEntry;
          byteIdx_d = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (!lastByte) begin
            byteIdx_d = byteIdx_q + 1'b1;
          end else if (!fifoEmpty) begin
            pop       = 1'b1;
            shift_d   = rdEntry;
            byteIdx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Packet byte accounting: saturating running count, latched into the size on packet end
  always_comb begin
    runCnt_d  = runCnt_q;
    pktSize_d = pktSize_q;
    if (xfer) begin
      if (lastByte && shift_q.last) begin
        pktSize_d = runInc;
        runCnt_d  = '0;
      end else begin
        runCnt_d = runInc;
      end
    end
  end

  // Outputs: byte lane selection by transmit order, plus valid/last/busy decode
  always_comb begin
    byteSel = MSB_FIRST ? (LAST_IDX - byteIdx_q) : byteIdx_q;
    outByte = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (IDX_W'(b) == byteSel) outByte = shift_q.word[b*BYTE_W +: BYTE_W];
    end
    tValid = (state_q == SEND);
    tLast  = tValid && lastByte && shift_q.last;
    busy   = !fifoEmpty || (state_q == SEND);
  end

  // Datapath registers; overflow stays set until reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_q    <= '0;
      byteIdx_q  <= '0;
      runCnt_q   <= '0;
      pktSize_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      byteIdx_q  <= byteIdx_d;
      runCnt_q   <= runCnt_d;
      pktSize_q  <= pktSize_d;
      overflow_q <= overflow_q | (bus.i_enb && fifoFull);
    end
  end

  assign bus.o_ready                = (fifoCount != CNT_W'(FIFO_DEPTH));
  assign bus.o_overflow             = overflow_q;
  assign bus.o_tanswer_ready        = tValid;
  assign bus.o_tanswer_data         = tValid ? outByte : '0;
  assign bus.o_tanswer_data_last    = tLast;
  assign bus.o_packet_size_in_bytes = pktSize_q;
  assign bus.o_busy                 = busy;

endmodule

// File: tb/tb_word_serializer_fifo.sv
// Self-checking bench: two serializers (MSB-first and LSB-first) share stimulus and
// are compared against a byte-stream reference model built from pushed words.
module tb_word_serializer_fifo;

  localparam int WB      = 4;
  localparam int DEPTH   = 8;
  localparam int SW      = 12;
  localparam int PKT_MAX = (1 << SW) - 1;

  typedef struct packed {
    logic       wordEnd;
    logic       last;
    logic [7:0] b;
  } exp_byte_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  exp_byte_t expQA[$];
  exp_byte_t expQB[$];
  int        inFlight  = 0;
  int        runCount  = 0;
  int        expPkt    = 0;
  int        xferCount = 0;
  logic      expOvf    = 1'b0;
  logic      prevStall = 1'b0;
  logic [7:0] prevDataA, prevDataB;
  logic       prevLastA, prevLastB;

  always #5 clk = ~clk;

  word_serializer_fifo_if #(.WORD_BYTES(WB), .SIZE_W(SW)) busA ();
  word_serializer_fifo_if #(.WORD_BYTES(WB), .SIZE_W(SW)) busB ();

  word_serializer_fifo #(
    .WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1), .SIZE_W(SW)
  ) dutA (
    .i_clk(clk), .i_rst(rst), .bus(busA)
  );

  word_serializer_fifo #(
    .WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0), .SIZE_W(SW)
  ) dutB (
    .i_clk(clk), .i_rst(rst), .bus(busB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic setInputs(input logic enb, input logic [WB*8-1:0] data, input logic lastIn, input logic tmRdy);
    busA.i_enb = enb;  busA.i_data = data;  busA.i_last = lastIn;  busA.i_tmanager_ready = tmRdy;
    busB.i_enb = enb;  busB.i_data = data;  busB.i_last = lastIn;  busB.i_tmanager_ready = tmRdy;
  endtask

  // Reference model: a word expands into WB bytes in each DUT's transmit order
  function automatic void modelPush(input logic [WB*8-1:0] w, input logic l);
    exp_byte_t eA, eB;
    for (int k = 0; k < WB; k++) begin
      eA.b       = w[(WB-1-k)*8 +: 8];
      eB.b       = w[k*8 +: 8];
      eA.wordEnd = (k == WB - 1);
      eB.wordEnd = (k == WB - 1);
      eA.last    = l && (k == WB - 1);
      eB.last    = l && (k == WB - 1);
      expQA.push_back(eA);
      expQB.push_back(eB);
    end
    inFlight++;
  endfunction

  // One clock cycle: drive inputs, check observed outputs against the model, advance the model
  task automatic applyStimulus(input logic enb, input logic [WB*8-1:0] data, input logic lastIn,
                               input logic tmRdy, input logic expAccept);
    exp_byte_t eA, eB;
    @(posedge clk);
    #1;
    rst = 1'b0;
    setInputs(enb, data, lastIn, tmRdy);
    checkOutput("busyA", busA.o_busy, inFlight != 0);
    checkOutput("busyB", busB.o_busy, inFlight != 0);
    checkOutput("pktA", busA.o_packet_size_in_bytes, expPkt);
    checkOutput("pktB", busB.o_packet_size_in_bytes, expPkt);
    checkOutput("ovfA", busA.o_overflow, expOvf);
    checkOutput("ovfB", busB.o_overflow, expOvf);
    if (prevStall) begin
      checkOutput("stallValidA", busA.o_tanswer_ready, 1'b1);
      checkOutput("stallDataA", busA.o_tanswer_data, prevDataA);
      checkOutput("stallLastA", busA.o_tanswer_data_last, prevLastA);
      checkOutput("stallDataB", busB.o_tanswer_data, prevDataB);
      checkOutput("stallLastB", busB.o_tanswer_data_last, prevLastB);
    end
    if (expQA.size() == 0) begin
      checkOutput("idleValidA", busA.o_tanswer_ready, 1'b0);
      checkOutput("idleValidB", busB.o_tanswer_ready, 1'b0);
    end
    if (busA.o_tanswer_ready && tmRdy && expQA.size() != 0) begin
      eA = expQA.pop_front();
      eB = expQB.pop_front();
      checkOutput("dataA", busA.o_tanswer_data, eA.b);
      checkOutput("lastA", busA.o_tanswer_data_last, eA.last);
      checkOutput("validB", busB.o_tanswer_ready, 1'b1);
      checkOutput("dataB", busB.o_tanswer_data, eB.b);
      checkOutput("lastB", busB.o_tanswer_data_last, eB.last);
      xferCount++;
      if (eA.last) begin
        expPkt   = (runCount + 1 > PKT_MAX) ? PKT_MAX : runCount + 1;
        runCount = 0;
      end else begin
        runCount = (runCount + 1 > PKT_MAX) ? PKT_MAX : runCount + 1;
      end
      if (eA.wordEnd) inFlight--;
    end
    prevStall = busA.o_tanswer_ready && !tmRdy;
    prevDataA = busA.o_tanswer_data;
    prevDataB = busB.o_tanswer_data;
    prevLastA = busA.o_tanswer_data_last;
    prevLastB = busB.o_tanswer_data_last;
    if (enb) begin
      checkOutput("readyA", busA.o_ready, expAccept);
      checkOutput("readyB", busB.o_ready, expAccept);
      if (expAccept) modelPush(data, lastIn);
      else           expOvf = 1'b1;
    end
  endtask

  // One reset cycle, then check every output is back at its reset value
  task automatic resetCycle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    setInputs(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQA.delete();
    expQB.delete();
    inFlight  = 0;
    runCount  = 0;
    expPkt    = 0;
    expOvf    = 1'b0;
    prevStall = 1'b0;
    checkOutput("rstValid", busA.o_tanswer_ready, 1'b0);
    checkOutput("rstData", busA.o_tanswer_data, 8'h00);
    checkOutput("rstLast", busA.o_tanswer_data_last, 1'b0);
    checkOutput("rstPkt", busA.o_packet_size_in_bytes, 0);
    checkOutput("rstOvf", busA.o_overflow, 1'b0);
    checkOutput("rstBusy", busA.o_busy, 1'b0);
    checkOutput("rstReady", busA.o_ready, 1'b1);
    checkOutput("rstReadyB", busB.o_ready, 1'b1);
    checkOutput("rstPktB", busB.o_packet_size_in_bytes, 0);
  endtask

  task automatic drain();
    int guard = 0;
    while ((expQA.size() != 0 || inFlight != 0) && guard < 2000) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    checkOutput("drainLeft", expQA.size(), 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int sent;
    int guard;
    logic [3:0] bpPattern;
    setInputs(1'b0, '0, 1'b0, 1'b0);
    resetCycle();

    // Single word: first byte two cycles after the write, packet size 4
    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("latN1", busA.o_tanswer_ready, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("latN2", busA.o_tanswer_ready, 1'b1);
    checkOutput("firstA", busA.o_tanswer_data, 8'hA1);
    checkOutput("firstB", busB.o_tanswer_data, 8'hD4);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("singlePkt", busA.o_packet_size_in_bytes, 4);
    checkOutput("singleBusy", busA.o_busy, 1'b0);

    // Backpressure across two words, ready pattern 1,0,0,1
    bpPattern = 4'b1001;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(i < 2, (i == 0) ? 32'h11223344 : 32'h55667788, i == 1, bpPattern[i % 4], 1'b1);
    end
    drain();
    checkOutput("bpPkt", busA.o_packet_size_in_bytes, 8);

    // Overflow with downstream stalled: one word sits in the serializer, DEPTH in the FIFO
    for (int i = 0; i < DEPTH + 2; i++) begin
      applyStimulus(1'b1, 32'hC0DE0000 + 32'(i), i == DEPTH, 1'b0, i < DEPTH + 1);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovfFlag", busA.o_overflow, 1'b1);
    base = xferCount;
    drain();
    checkOutput("ovfBytes", xferCount - base, (DEPTH + 1) * WB);
    checkOutput("ovfPkt", busA.o_packet_size_in_bytes, (DEPTH + 1) * WB);
    checkOutput("ovfSticky", busA.o_overflow, 1'b1);
    resetCycle();

    // Back-to-back: three queued words stream with no bubble
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h0BAD0000 + 32'(i), i == 2, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("b2bValid", busA.o_tanswer_ready, 1'b1);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("b2bBusy", busA.o_busy, 1'b0);
    checkOutput("b2bPkt", busA.o_packet_size_in_bytes, 12);

    // Reset while the third byte of a word is on the bus
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    resetCycle();
    applyStimulus(1'b1, 32'h01020304, 1'b1, 1'b1, 1'b1);
    drain();
    checkOutput("postRstPkt", busA.o_packet_size_in_bytes, 4);

    // Randomized traffic and backpressure
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0) && (inFlight < DEPTH), $urandom,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, 1'b1);
    end
    drain();

    // Saturation: a packet longer than the counter can represent
    sent  = 0;
    guard = 0;
    while ((sent < 1030) && (guard < 20000)) begin
      if (inFlight < DEPTH) begin
        applyStimulus(1'b1, $urandom, sent == 1029, 1'b1, 1'b1);
        sent++;
      end else begin
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      end
      guard++;
    end
    checkOutput("satSent", sent, 1030);
    drain();
    checkOutput("satPkt", busA.o_packet_size_in_bytes, PKT_MAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
